// File: rtl/mul_sequencer.sv
// mul_sequencer: drives a register-mapped multiplier through a fixed
// write-X / write-Y / read-product sequence and returns the product.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. req_ready is 1 only in IDLE and res_valid only in DONE,
// and neither depends on valid/ready inputs. So requests are never queued
// and a result holds until the consumer takes it.
//
// Optional build macro MUL_SEQUENCER_CHECK_EN: compares the product returned
// by the multiplier with the locally computed X*Y and raises a sticky err.
// When the macro is undefined, err is tied to 0.
module mul_sequencer #(
  parameter logic [1:0] X_ADDR = 2'd0,
  parameter logic [1:0] Y_ADDR = 2'd1,
  parameter logic [1:0] P_ADDR = 2'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_x,
  input  logic [15:0] req_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res,
  output logic [15:0] mul_d,
  output logic [1:0]  mul_addr,
  output logic        mul_w,
  output logic        mul_r,
  output logic        mul_e,
  input  logic [31:0] mul_out,
  output logic        err,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WX   = 3'd1,
    WY   = 3'd2,
    RD   = 3'd3,
    CAP  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] x_q;
  logic [15:0] y_q;

  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and bus/handshake outputs, decoded from registered state only.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    res_valid  = 1'b0;
    mul_d      = 16'd0;
    mul_addr   = 2'd0;
    mul_w      = 1'b0;
    mul_r      = 1'b0;
    mul_e      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = WX;
      end
      WX: begin
        mul_addr   = X_ADDR;
        mul_d      = x_q;
        mul_w      = 1'b1;
        mul_e      = 1'b1;
        state_next = WY;
      end
      WY: begin
        mul_addr   = Y_ADDR;
        mul_d      = y_q;
        mul_w      = 1'b1;
        mul_e      = 1'b1;
        state_next = RD;
      end
      RD: begin
        mul_addr   = P_ADDR;
        mul_r      = 1'b1;
        mul_e      = 1'b1;
        state_next = CAP;
      end
      CAP: begin
        state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand latch on accept; product capture when leaving CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 16'd0;
      y_q <= 16'd0;
      res <= 32'd0;
    end else begin
      if (state == IDLE && req_valid) begin
        x_q <= req_x;
        y_q <= req_y;
      end
      if (state == CAP) begin
        res <= mul_out;
      end
    end
  end

`ifdef MUL_SEQUENCER_CHECK_EN
  logic [31:0] prod_local;

  assign prod_local = {16'd0, x_q} * {16'd0, y_q};

  // Sticky error: the multiplier's answer disagrees with the local product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == CAP && mul_out != prod_local) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter X_ADDR, default 0: MUL_ADDR value used for the operand-X write.
REQ-002 Parameter Y_ADDR, default 1: MUL_ADDR value used for the operand-Y write.
REQ-003 Parameter P_ADDR, default 2: MUL_ADDR value used for the product read.
REQ-004 CLK  input  1  single clock; all state updates on posedge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 REQ_VALID  input  1  request operands valid.
REQ-007 REQ_READY  output  1  sequencer accepts a request.
REQ-008 REQ_X, REQ_Y  input  16 each  unsigned operands.
REQ-009 RES_VALID  output  1  result valid.
REQ-010 RES_READY  input  1  consumer accepts the result.
REQ-011 RES  output  32  registered product.
REQ-012 MUL_D  output  16; MUL_ADDR  output  2; MUL_W, MUL_R, MUL_E  output  1 each: multiplier register-bus drive.
REQ-013 MUL_OUT  input  32  multiplier registered read data.
REQ-014 ERR  output  1  sticky self-check error flag.

Function
REQ-015 FSM states: IDLE, WX, WY, RD, CAP, DONE; one state per cycle, no waits except IDLE and DONE.
REQ-016 IDLE: REQ_READY=1; on posedge with REQ_VALID=1, latch REQ_X/REQ_Y into internal registers and go to WX; REQ_READY=0 in all other states.
REQ-017 WX: MUL_ADDR=X_ADDR, MUL_D=latched X, MUL_W=1, MUL_R=0, MUL_E=1; next RD-chain state WY.
REQ-018 WY: MUL_ADDR=Y_ADDR, MUL_D=latched Y, MUL_W=1, MUL_R=0, MUL_E=1; next RD.
REQ-019 RD: MUL_ADDR=P_ADDR, MUL_W=0, MUL_R=1, MUL_E=1, MUL_D=0; next CAP.
REQ-020 CAP: all MUL_* outputs 0; RES<=MUL_OUT on the posedge leaving CAP; next DONE.
REQ-021 DONE: RES_VALID=1, RES stable; on posedge with RES_READY=1 go to IDLE; otherwise hold RES, RES_VALID indefinitely.
REQ-022 In IDLE, CAP, DONE all MUL_* outputs are 0; MUL_W and MUL_R never both 1.
REQ-023 Latency: RES_VALID rises exactly 5 posedges after the accept edge (accept, WX, WY, RD, CAP edges); throughput one op per 6 cycles with RES_READY held 1.
REQ-024 Request changes on REQ_X/REQ_Y after acceptance do not affect the operation in flight.
REQ-025 RES_READY outside DONE is ignored; REQ_VALID outside IDLE is ignored (no queuing).
REQ-026 All FSM outputs decoded from registered state only; no combinational input-to-output path.

Reset
REQ-027 RST_N=0 forces, asynchronously: state IDLE, REQ_READY=1 after release-independent decode, RES_VALID=0, RES=0, all MUL_*=0, ERR=0, latched operands=0.
REQ-028 Reset asserted mid-operation abandons the operation; no partial result is presented; first post-reset request is handled normally.

Configuration
REQ-029 Macro MUL_SEQUENCER_CHECK_EN defined: at the CAP edge compare MUL_OUT with latched X*Y (32-bit unsigned); on mismatch set ERR=1, held until reset; RES still captures MUL_OUT.
REQ-030 Macro undefined: no compare logic is built; ERR tied 0.

Verification
REQ-031 Request X=4, Y=5, RES_READY=1, multiplier model attached -> bus sequence addr 0/D=4/W, addr 1/D=5/W, addr 2/R; RES=20 with RES_VALID 5 edges after accept.
REQ-032 Back-to-back X=445,Y=100 then X=65535,Y=65535 -> RES=44500 then RES=0xFFFE0001; REQ_READY only in IDLE.
REQ-033 X=7,Y=9, RES_READY=0 for 8 cycles in DONE, REQ_VALID=1 with X=1 meanwhile -> RES=63 held, second request not accepted until after RES handshake.
REQ-034 Assert RST_N=0 during RD of X=3,Y=3 -> all outputs reset immediately; following X=2,Y=8 yields RES=16.
REQ-035 With MUL_SEQUENCER_CHECK_EN, multiplier model returning product+1 for X=6,Y=6 -> RES=37, ERR=1 sticky; without macro ERR stays 0.
